aftab_daru_read_sequencer: RTL and testbench

Byte-serial read sequencer of the AFTAB DARU (Data Alignment Read Unit). It takes a load or instruction-fetch request, presents nBytes and the low address bits to the misalignment detector, and gets a flag back. It then either aborts, or issues 1/2/4 byte reads to byte-wide memory. It assembles the bytes little-endian, sign- or zero-extends the result, and signals completion to the core controller.

---
 rtl/aftab_daru_pkg.sv | 22 ++
 rtl/aftab_daru_byte_assembler.sv | 52 +++++
 rtl/aftab_daru_read_sequencer.sv | 124 ++++++++++++
 tb/tb_aftab_daru_read_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/aftab_daru_pkg.sv
// Shared types and constants for the AFTAB DARU read sequencer.
package aftab_daru_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_DONE  = 2'b10,
        ST_ABORT = 2'b11
    } daru_state_t;

    localparam logic [1:0] NB_BYTE = 2'b00;
    localparam logic [1:0] NB_HALF = 2'b01;
    localparam logic [1:0] NB_WORD = 2'b11;

    // Index of the final byte per nBytes code; the reserved code 2'b10 reads as a word.
    localparam logic [7:0] LAST_BYTE_LUT = {2'd3, 2'd3, 2'd1, 2'd0};

    function automatic logic [1:0] last_byte(input logic [1:0] nb);
        return LAST_BYTE_LUT[{nb, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/aftab_daru_byte_assembler.sv
// Little-endian lane assembly register with sign/zero extension of the merged result.
module aftab_daru_byte_assembler
    import aftab_daru_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            write_en,
    input  logic [1:0]      lane_sel,
    input  logic [7:0]      mem_data,
    input  logic [1:0]      nbytes,
    input  logic            unsigned_load,
    input  logic            data_inst_bar,
    output logic [size-1:0] extended_c
);

    logic [size-1:0] asm_q;
    logic [size-1:0] merged;
    logic            sign_ext;

    // Merge the incoming byte so the extended value is ready in the same cycle it arrives.
    always_comb begin
        merged = asm_q;
        if (write_en) begin
            merged[{lane_sel, 3'b000} +: 8] = mem_data;
        end
    end

    assign sign_ext = data_inst_bar & ~unsigned_load;

    always_comb begin
        extended_c = merged;
        if (nbytes == NB_BYTE) begin
            extended_c = {{(size-8){sign_ext & merged[7]}}, merged[7:0]};
        end else if (nbytes == NB_HALF) begin
            extended_c = {{(size-16){sign_ext & merged[15]}}, merged[15:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= '0;
        end else if (clear) begin
            asm_q <= '0;
        end else begin
            asm_q <= merged;
        end
    end

endmodule

// File: rtl/aftab_daru_read_sequencer.sv
// Byte-serial read sequencer: misalignment check, 1/2/4 byte reads, assembly and extension.
module aftab_daru_read_sequencer
    import aftab_daru_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startDARU,
    input  logic            dataInstBar,
    input  logic [1:0]      nBytes,
    input  logic            unsignedLoad,
    input  logic [size-1:0] addrIn,
    input  logic            misalignedFlag,
    output logic [1:0]      nBytesOut,
    output logic [1:0]      addrLowOut,
    output logic            checkMisalignedDARU,
    output logic            memRead,
    output logic [size-1:0] memAddr,
    input  logic [7:0]      memDataIn,
    input  logic            memReady,
    output logic [size-1:0] dataOut,
    output logic            completeDARU,
    output logic            abortDARU,
    output logic            busyDARU
);

    daru_state_t     state_q, state_d;
    logic [size-1:0] mem_addr_q;
    logic [size-1:0] data_out_q;
    logic [1:0]      byte_cnt_q;
    logic [1:0]      nb_q;
    logic            unsigned_q;
    logic            data_inst_q;
    logic            accept;
    logic            beat;
    logic            last_beat;
    logic [size-1:0] extended;

    assign nBytesOut  = nBytes;
    assign addrLowOut = addrIn[1:0];

    assign accept    = (state_q == ST_IDLE) & startDARU & ~misalignedFlag;
    assign beat      = (state_q == ST_READ) & memReady;
    assign last_beat = beat & (byte_cnt_q == last_byte(nb_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (startDARU) state_d = misalignedFlag ? ST_ABORT : ST_READ;
            ST_READ:  if (last_beat) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        checkMisalignedDARU = 1'b0;
        memRead             = 1'b0;
        completeDARU        = 1'b0;
        abortDARU           = 1'b0;
        busyDARU            = 1'b1;
        case (state_q)
            ST_IDLE:  begin
                busyDARU            = 1'b0;
                checkMisalignedDARU = startDARU;
            end
            ST_READ:  memRead      = 1'b1;
            ST_DONE:  completeDARU = 1'b1;
            ST_ABORT: abortDARU    = 1'b1;
            default:  busyDARU     = 1'b1;
        endcase
    end

    // Request capture, wrapping address counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q  <= '0;
            byte_cnt_q  <= '0;
            nb_q        <= NB_BYTE;
            unsigned_q  <= 1'b0;
            data_inst_q <= 1'b0;
            data_out_q  <= '0;
        end else if (accept) begin
            mem_addr_q  <= addrIn;
            byte_cnt_q  <= '0;
            nb_q        <= nBytes;
            unsigned_q  <= unsignedLoad;
            data_inst_q <= dataInstBar;
        end else if (beat) begin
            mem_addr_q <= mem_addr_q + size'(1);
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (last_beat) begin
                data_out_q <= extended;
            end
        end
    end

    aftab_daru_byte_assembler #(.size(size)) u_assembler (
        .clk           (clk),
        .rst           (rst),
        .clear         (accept),
        .write_en      (beat),
        .lane_sel      (byte_cnt_q),
        .mem_data      (memDataIn),
        .nbytes        (nb_q),
        .unsigned_load (unsigned_q),
        .data_inst_bar (data_inst_q),
        .extended_c    (extended)
    );

    assign memAddr = mem_addr_q;
    assign dataOut = data_out_q;

endmodule

// File: tb/tb_aftab_daru_read_sequencer.sv
// Directed self-checking bench for aftab_daru_read_sequencer.
module tb_aftab_daru_read_sequencer;
    import aftab_daru_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        startDARU;
    logic        dataInstBar;
    logic [1:0]  nBytes;
    logic        unsignedLoad;
    logic [31:0] addrIn;
    logic        misalignedFlag;
    logic [1:0]  nBytesOut;
    logic [1:0]  addrLowOut;
    logic        checkMisalignedDARU;
    logic        memRead;
    logic [31:0] memAddr;
    logic [7:0]  memDataIn;
    logic        memReady;
    logic [31:0] dataOut;
    logic        completeDARU;
    logic        abortDARU;
    logic        busyDARU;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aftab_daru_read_sequencer #(.size(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .startDARU           (startDARU),
        .dataInstBar         (dataInstBar),
        .nBytes              (nBytes),
        .unsignedLoad        (unsignedLoad),
        .addrIn              (addrIn),
        .misalignedFlag      (misalignedFlag),
        .nBytesOut           (nBytesOut),
        .addrLowOut          (addrLowOut),
        .checkMisalignedDARU (checkMisalignedDARU),
        .memRead             (memRead),
        .memAddr             (memAddr),
        .memDataIn           (memDataIn),
        .memReady            (memReady),
        .dataOut             (dataOut),
        .completeDARU        (completeDARU),
        .abortDARU           (abortDARU),
        .busyDARU            (busyDARU)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue an aligned request with memReady high every cycle; optionally re-pulse start mid-read.
    task automatic run_xfer(input string tag, input logic [31:0] addr, input logic [1:0] nb,
                            input logic uns, input logic dib, input logic [31:0] bytes,
                            input int n, input int repulse, input logic [31:0] exp);
        addrIn = addr; nBytes = nb; unsignedLoad = uns; dataInstBar = dib;
        misalignedFlag = 1'b0; memReady = 1'b1; memDataIn = bytes[7:0]; startDARU = 1'b1;
        #1 chk({tag, "_chkmis"}, 32'(checkMisalignedDARU), 32'd1);
        step();
        startDARU = 1'b0; addrIn = 32'hDEAD0000; nBytes = NB_BYTE; unsignedLoad = ~uns; dataInstBar = ~dib;
        for (int i = 0; i < n; i++) begin
            memDataIn = bytes[8*i +: 8];
            startDARU = (i == repulse);
            if (i == repulse) addrIn = 32'h00005000;
            #1;
            chk({tag, "_addr"}, memAddr, addr + 32'(i));
            chk({tag, "_rd"}, 32'(memRead), 32'd1);
            chk({tag, "_cmp_early"}, 32'(completeDARU), 32'd0);
            if (i == repulse) chk({tag, "_chkmis_busy"}, 32'(checkMisalignedDARU), 32'd0);
            step();
        end
        startDARU = 1'b0;
        chk({tag, "_cmp"}, 32'(completeDARU), 32'd1);
        chk({tag, "_rd_off"}, 32'(memRead), 32'd0);
        chk({tag, "_abort"}, 32'(abortDARU), 32'd0);
        chk({tag, "_data"}, dataOut, exp);
        step();
        chk({tag, "_cmp_once"}, 32'(completeDARU), 32'd0);
        chk({tag, "_idle"}, 32'(busyDARU), 32'd0);
        chk({tag, "_hold"}, dataOut, exp);
    endtask

    initial begin
        rst = 1'b1; startDARU = 1'b0; dataInstBar = 1'b1; nBytes = NB_BYTE; unsignedLoad = 1'b0;
        addrIn = '0; misalignedFlag = 1'b0; memDataIn = '0; memReady = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_rd", 32'(memRead), 32'd0);
        chk("rst_busy", 32'(busyDARU), 32'd0);
        chk("rst_cmp", 32'(completeDARU), 32'd0);
        chk("rst_abort", 32'(abortDARU), 32'd0);
        chk("rst_addr", memAddr, 32'd0);
        chk("rst_data", dataOut, 32'd0);
        rst = 1'b0;
        step();

        // Signed byte load
        addrIn = 32'h00001003; nBytes = NB_BYTE;
        #1 chk("sb_nbout", 32'(nBytesOut), 32'd0);
        chk("sb_alow", 32'(addrLowOut), 32'd3);
        chk("sb_chk_noreq", 32'(checkMisalignedDARU), 32'd0);
        run_xfer("sb", 32'h00001003, NB_BYTE, 1'b0, 1'b1, 32'h00000080, 1, -1, 32'hFFFFFF80);

        // Unsigned halfword with a one-cycle memReady stall
        addrIn = 32'h00002000; nBytes = NB_HALF; unsignedLoad = 1'b1; dataInstBar = 1'b1;
        misalignedFlag = 1'b0; memReady = 1'b1; memDataIn = 8'h34; startDARU = 1'b1;
        step();
        startDARU = 1'b0;
        #1 chk("uh_addr0", memAddr, 32'h00002000);
        chk("uh_rd0", 32'(memRead), 32'd1);
        step();
        memReady = 1'b0; memDataIn = 8'hAA;
        #1 chk("uh_addr1", memAddr, 32'h00002001);
        step();
        chk("uh_stall_rd", 32'(memRead), 32'd1);
        chk("uh_stall_addr", memAddr, 32'h00002001);
        chk("uh_stall_cmp", 32'(completeDARU), 32'd0);
        memReady = 1'b1; memDataIn = 8'h92;
        step();
        chk("uh_cmp", 32'(completeDARU), 32'd1);
        chk("uh_data", dataOut, 32'h00009234);
        step();
        chk("uh_cmp_once", 32'(completeDARU), 32'd0);

        // Word instruction fetch at the top of memory
        run_xfer("wf", 32'hFFFFFFFC, NB_WORD, 1'b0, 1'b0, 32'h80000513, 4, -1, 32'h80000513);

        // Byte fetch zero-extends even with unsignedLoad low
        run_xfer("bf", 32'h00000010, NB_BYTE, 1'b0, 1'b0, 32'h000000F0, 1, -1, 32'h000000F0);

        // Signed halfword with negative top byte
        run_xfer("sh", 32'h00000020, NB_HALF, 1'b0, 1'b1, 32'h000081FE, 2, -1, 32'hFFFF81FE);

        // Misaligned halfword aborts without reading
        addrIn = 32'h00003001; nBytes = NB_HALF; unsignedLoad = 1'b0; dataInstBar = 1'b1;
        misalignedFlag = 1'b1; startDARU = 1'b1;
        #1 chk("mis_chk", 32'(checkMisalignedDARU), 32'd1);
        chk("mis_alow", 32'(addrLowOut), 32'd1);
        step();
        startDARU = 1'b0; misalignedFlag = 1'b0;
        chk("mis_abort", 32'(abortDARU), 32'd1);
        chk("mis_rd", 32'(memRead), 32'd0);
        chk("mis_cmp", 32'(completeDARU), 32'd0);
        chk("mis_data", dataOut, 32'hFFFF81FE);
        step();
        chk("mis_abort_once", 32'(abortDARU), 32'd0);
        chk("mis_rd2", 32'(memRead), 32'd0);
        chk("mis_idle", 32'(busyDARU), 32'd0);

        // Start re-pulsed mid-read is ignored
        run_xfer("rp", 32'h00004000, NB_WORD, 1'b0, 1'b1, 32'h44332211, 4, 1, 32'h44332211);

        // Reserved nBytes code behaves as a word
        run_xfer("nb10", 32'h00008000, 2'b10, 1'b0, 1'b1, 32'h84030201, 4, -1, 32'h84030201);

        // Asynchronous reset after two bytes of a word
        addrIn = 32'h00006000; nBytes = NB_WORD; unsignedLoad = 1'b0; dataInstBar = 1'b1;
        misalignedFlag = 1'b0; memReady = 1'b1; memDataIn = 8'h11; startDARU = 1'b1;
        step();
        startDARU = 1'b0;
        step();
        memDataIn = 8'h22;
        step();
        chk("ar_mid_rd", 32'(memRead), 32'd1);
        chk("ar_mid_addr", memAddr, 32'h00006002);
        #2 rst = 1'b1;
        #1 chk("ar_rd_drop", 32'(memRead), 32'd0);
        chk("ar_data", dataOut, 32'd0);
        chk("ar_busy", 32'(busyDARU), 32'd0);
        chk("ar_addr", memAddr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        run_xfer("ar_next", 32'h00007000, NB_HALF, 1'b0, 1'b1, 32'h0000FFFE, 2, -1, 32'hFFFFFFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
